mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences every data-memory access of the multicycle CPU.
- Accepts a load/store request from the main control FSM.
- Checks alignment and generates byte enables and lane-replicated write data.
- Drives a req/ack handshake to data memory with timeout.
- Returns an aligned, sign- or zero-extended load result.
- Replaces the ad hoc MemRead/MemWrite strobes with a single done pulse the control FSM waits on.

Parameters:
TIMEOUT, 16, cycles mem_req may stay unacknowledged before bus_err (must be >= 2).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req  input  1  start access; sampled only in IDLE
we  input  1  1 = store (SW/SH/SB), 0 = load
size  input  2  00 word, 01 half, 10 byte, 11 invalid
sign_ext  input  1  loads only: 1 = LB/LH, 0 = LBU/LHU
addr  input  32  byte address (ALUOut)
wdata  input  32  store data, value in low bits
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result; holds until next completed load
addr_err  output  1  pulses with done on misaligned or invalid access
bus_err  output  1  pulses with done on timeout
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  write strobe, valid while mem_req
mem_addr  output  32  {addr[31:2],2'b00}
mem_be  output  4  lane enables, valid while mem_req
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completion; sampled only in ACCESS
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE, timeout counter 0; all outputs 0, including rdata. Reset wins over every other event. Reset during ACCESS drops mem_req at that edge and produces no done.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE + req: latch we, size, sign_ext, addr, wdata, and computed be.
  - Misaligned or invalid → ERR. Misaligned means word with addr[1:0]!=0, or half with addr[0]=1. Invalid means size=11.
  - Otherwise → ACCESS.
- req while busy: ignored, no queueing.
- ERR: done=1, addr_err=1 for one cycle, then IDLE. No mem_req is ever issued.
- ACCESS:
  - mem_req=1, with mem_addr/mem_be/mem_wdata/mem_we driven from registers and stable throughout.
  - mem_ack=1 → RESP; capture mem_rdata on loads.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no ack → ERR-like exit: done=1, bus_err=1, mem_req deasserted, then IDLE.
- RESP: done=1 for one cycle; rdata updated for loads, unchanged for stores; → IDLE.
- Latency: req sampled at edge 0; mem_req high cycle 1; zero-wait ack in cycle 1; done in cycle 2. Each wait cycle adds 1.
- mem_ack outside ACCESS: ignored.
- Byte enables (loads and stores):
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Write data: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- Load extract:
  - byte = mem_rdata[8*addr[1:0] +: 8]
  - half = mem_rdata[16*addr[1] +: 16]
  - then sign- or zero-extend to 32 bits.
- done, addr_err, and bus_err are never high outside their single cycle. addr_err and bus_err are mutually exclusive.

Decomposition:
- Package mem_access_pkg holds:
  - SIZE_WORD/SIZE_HALF/SIZE_BYTE encodings, shared with the control unit's StoreType/LoadType decode
  - state encoding
- Sub-module lane_align (combinational) computes be, replicated wdata, misalign flag, and load extraction/extension.
- The FSM, registers, and timeout counter stay in mem_access_ctrl.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, ack in cycle 1 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1, done in cycle 2.
- LH sign_ext=1, addr=0x2002, mem_rdata=0x8001_1234, ack after 3 waits → rdata=0xFFFF8001, done 5 cycles after req.
- LBU, addr=0x2001, mem_rdata=0x00_00_F0_00 → rdata=0x000000F0. Repeat with LB → rdata=0xFFFFFFF0.
- SW addr=0x3002, then SH addr=0x3001, then size=11 → each gives done+addr_err 1 cycle after req, mem_req never asserted.
- LW with mem_ack held 0 → mem_req high exactly TIMEOUT cycles, then done+bus_err; next req proceeds normally.
- Reset asserted during ACCESS wait → next cycle mem_req=0, busy=0, no done; req issued during busy in a separate run is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access sequencer.
// Size encodings match the control unit's StoreType/LoadType decode.
package mem_access_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: enables, store replication, misalign check,
// and load extraction with sign/zero extension.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic        bad,
    output logic [31:0] lval
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bsel = rword[{lane, 3'b000} +: 8];
    assign hsel = rword[{lane[1], 4'b0000} +: 16];

    // Decode size into lane enables, replicated data and extended load value.
    always_comb begin
        be   = 4'b0000;
        wrep = wdata;
        bad  = 1'b0;
        lval = rword;
        case (size)
            SIZE_WORD: begin
                be   = 4'b1111;
                wrep = wdata;
                bad  = (lane != 2'b00);
                lval = rword;
            end
            SIZE_HALF: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
                bad  = lane[0];
                lval = {{16{sign_ext & hsel[15]}}, hsel};
            end
            SIZE_BYTE: begin
                be   = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
                bad  = 1'b0;
                lval = {{24{sign_ext & bsel[7]}}, bsel};
            end
            default: begin
                be   = 4'b0000;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: one request in, one done pulse out,
// with alignment checking and a bounded wait on the memory ack.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t      state, nstate;
    logic [CW-1:0] cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        tmo_q;
    logic [31:0] rdata_q;

    logic        idle;
    logic [1:0]  la_size;
    logic [1:0]  la_lane;
    logic        la_sign;
    logic [3:0]  la_be;
    logic [31:0] la_wrep;
    logic        la_bad;
    logic [31:0] la_lval;

    assign idle    = (state == ST_IDLE);
    assign la_size = idle ? size : size_q;
    assign la_lane = idle ? addr[1:0] : addr_q[1:0];
    assign la_sign = idle ? sign_ext : sign_q;

    lane_align u_align (
        .size     (la_size),
        .lane     (la_lane),
        .sign_ext (la_sign),
        .wdata    (wdata),
        .rword    (mem_rdata),
        .be       (la_be),
        .wrep     (la_wrep),
        .bad      (la_bad),
        .lval     (la_lval)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        nstate   = state;
        busy     = 1'b1;
        done     = 1'b0;
        addr_err = 1'b0;
        bus_err  = 1'b0;
        mem_req  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) nstate = la_bad ? ST_ERR : ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack)         nstate = ST_RESP;
                else if (cnt == LAST) nstate = ST_ERR;
            end
            ST_RESP: begin
                done   = 1'b1;
                nstate = ST_IDLE;
            end
            ST_ERR: begin
                done     = 1'b1;
                addr_err = ~tmo_q;
                bus_err  = tmo_q;
                nstate   = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // Request latch, timeout counter and load result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (idle && req) begin
                cnt     <= '0;
                we_q    <= we;
                size_q  <= size;
                sign_q  <= sign_ext;
                addr_q  <= addr;
                be_q    <= la_be;
                wdata_q <= la_wrep;
                tmo_q   <= 1'b0;
            end else if (state == ST_ACCESS) begin
                if (mem_ack) begin
                    if (!we_q) rdata_q <= la_lval;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) tmo_q <= 1'b1;
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl.
// Hand-computed vectors over stores, loads, errors, timeout and reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] d);
        req = 1'b1; we = w; size = sz; sign_ext = sx;
        addr = a; wdata = d;
        step();
        req = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".mreq"}, 32'(mem_req), 32'd0);
    endtask

    task automatic chk_aerr(input string tag);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".aerr"}, 32'(addr_err), 32'd1);
        check({tag, ".berr"}, 32'(bus_err), 32'd0);
        check({tag, ".mreq"}, 32'(mem_req), 32'd0);
        step();
        chk_idle({tag, ".after"});
        check({tag, ".aerr1"}, 32'(addr_err), 32'd0);
    endtask

    task automatic load(input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] word,
                        input logic [31:0] exp, input string tag);
        issue(1'b0, sz, sx, a, 32'h0);
        check({tag, ".mreq"}, 32'(mem_req), 32'd1);
        check({tag, ".mwe"}, 32'(mem_we), 32'd0);
        mem_ack = 1'b1; mem_rdata = word;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".rdata"}, rdata, exp);
        step();
    endtask

    initial begin
        int n;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk_idle("rst");
        check("rst.rdata", rdata, 32'h0);
        check("rst.mbe", 32'(mem_be), 32'h0);
        check("rst.maddr", mem_addr, 32'h0);
        reset = 1'b0;
        step();

        // SB 0x1003
        issue(1'b1, 2'b10, 1'b0, 32'h1003, 32'h0000_00A5);
        check("sb.mreq", 32'(mem_req), 32'd1);
        check("sb.busy", 32'(busy), 32'd1);
        check("sb.mbe", 32'(mem_be), 32'b1000);
        check("sb.mwd", mem_wdata, 32'hA5A5_A5A5);
        check("sb.maddr", mem_addr, 32'h1000);
        check("sb.mwe", 32'(mem_we), 32'd1);
        check("sb.done1", 32'(done), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sb.done", 32'(done), 32'd1);
        check("sb.aerr", 32'(addr_err), 32'd0);
        check("sb.berr", 32'(bus_err), 32'd0);
        check("sb.mreq2", 32'(mem_req), 32'd0);
        check("sb.rdata", rdata, 32'h0);
        step();
        chk_idle("sb.end");

        // SH 0x1002 upper half
        issue(1'b1, 2'b01, 1'b0, 32'h1002, 32'h0000_BEEF);
        check("sh.mbe", 32'(mem_be), 32'b1100);
        check("sh.mwd", mem_wdata, 32'hBEEF_BEEF);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        check("sh.done", 32'(done), 32'd1);
        step();

        // LH 0x2002 with 3 waits
        issue(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("lh.wait%0d.mreq", i), 32'(mem_req), 32'd1);
            check($sformatf("lh.wait%0d.done", i), 32'(done), 32'd0);
            check($sformatf("lh.wait%0d.mbe", i), 32'(mem_be), 32'b1100);
            step();
        end
        check("lh.c4.mreq", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("lh.done", 32'(done), 32'd1);
        check("lh.rdata", rdata, 32'hFFFF_8001);
        step();
        chk_idle("lh.end");
        check("lh.hold", rdata, 32'hFFFF_8001);

        load(2'b10, 1'b0, 32'h2001, 32'h0000_F000, 32'h0000_00F0, "lbu");
        load(2'b10, 1'b1, 32'h2001, 32'h0000_F000, 32'hFFFF_FFF0, "lb");
        load(2'b01, 1'b0, 32'h2000, 32'h1234_8765, 32'h0000_8765, "lhu");
        load(2'b00, 1'b0, 32'h2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");

        // alignment / invalid errors
        issue(1'b1, 2'b00, 1'b0, 32'h3002, 32'h1);
        chk_aerr("sw.mis");
        issue(1'b1, 2'b01, 1'b0, 32'h3001, 32'h1);
        chk_aerr("sh.mis");
        issue(1'b0, 2'b11, 1'b0, 32'h3000, 32'h0);
        chk_aerr("inv");
        check("err.rhold", rdata, 32'hDEAD_BEEF);

        // timeout
        issue(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("tmo.cycles", 32'(n), 32'd16);
        check("tmo.done", 32'(done), 32'd1);
        check("tmo.berr", 32'(bus_err), 32'd1);
        check("tmo.aerr", 32'(addr_err), 32'd0);
        step();
        chk_idle("tmo.end");
        check("tmo.berr1", 32'(bus_err), 32'd0);
        load(2'b00, 1'b0, 32'h0040, 32'h1234_5678, 32'h1234_5678, "tmo.next");

        // reset during access wait
        issue(1'b0, 2'b00, 1'b0, 32'h5000, 32'h0);
        step();
        check("rst2.mreq0", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        chk_idle("rst2");
        check("rst2.rdata", rdata, 32'h0);
        reset = 1'b0;
        step();
        check("rst2.nodone", 32'(done), 32'd0);

        // req while busy is dropped
        issue(1'b0, 2'b00, 1'b0, 32'h0050, 32'h0);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h0060;
        wdata = 32'h1111_1111;
        check("busy.maddr", mem_addr, 32'h0050);
        step();
        check("busy.maddr2", mem_addr, 32'h0050);
        check("busy.mwe", 32'(mem_we), 32'd0);
        req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("busy.done", 32'(done), 32'd1);
        check("busy.rdata", rdata, 32'hCAFE_F00D);
        step();
        chk_idle("busy.end");
        step();
        chk_idle("busy.noq");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
